// File: rtl/seg7_monitor.sv
// seg7_monitor: debounces an active-low 7-segment pattern, decodes it to a hex
//   digit and reports acceptance, illegal patterns and the direction of change.
// Latency: an acceptance is registered on the STABLE_CYCLES-th consecutive edge
//   that samples the same pattern; every output is a register.
// Backpressure: none. seg7 is sampled on every edge and the pulses are fire-and-forget.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg7[6:0]    active-low segments, bit 6 = a ... bit 0 = g
//   digit[3:0]   last accepted hex value
//   valid        1-cycle pulse when a new legal digit is accepted
//   illegal      1-cycle pulse when a stable non-hex pattern is accepted
//   dir_up       1-cycle pulse with valid: new = previous + 1 (mod 16)
//   dir_down     1-cycle pulse with valid: new = previous - 1 (mod 16)
//   jump         1-cycle pulse with valid: any other change
//   accept_count saturating count of valid pulses since reset
module seg7_monitor #(
  parameter int unsigned STABLE_CYCLES = 4  // legal range 2..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg7,
  output logic [3:0] digit,
  output logic       valid,
  output logic       illegal,
  output logic       dir_up,
  output logic       dir_down,
  output logic       jump,
  output logic [7:0] accept_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam logic [7:0] SCNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] SCNT_PRE = 8'(STABLE_CYCLES - 1);
  // All-dark pattern: not in the legal table, so it never matches an accepted one.
  localparam logic [6:0] NO_PATTERN = 7'b1111111;

  state_e     state_q;
  logic [6:0] cand_q;
  logic [7:0] scnt_q;
  logic [6:0] held_q;
  logic [3:0] digit_q;
  logic       valid_q;
  logic       illegal_q;
  logic       up_q;
  logic       down_q;
  logic       jump_q;
  logic [7:0] count_q;

  logic       same_d;
  logic       accept_d;
  logic       legal_d;
  logic [3:0] dec_d;
  logic [3:0] inc_d;
  logic [3:0] dec1_d;
  logic       is_up_d;
  logic       is_down_d;
  logic [7:0] count_d;

  // Decoder for the sixteen legal hex glyphs.
  always_comb begin
    legal_d = 1'b1;
    dec_d   = 4'h0;
    case (seg7)
      7'b0000001: dec_d = 4'h0;
      7'b1001111: dec_d = 4'h1;
      7'b0010010: dec_d = 4'h2;
      7'b0000110: dec_d = 4'h3;
      7'b1001100: dec_d = 4'h4;
      7'b0100100: dec_d = 4'h5;
      7'b0100000: dec_d = 4'h6;
      7'b0001111: dec_d = 4'h7;
      7'b0000000: dec_d = 4'h8;
      7'b0000100: dec_d = 4'h9;
      7'b0001000: dec_d = 4'hA;
      7'b1100000: dec_d = 4'hB;
      7'b0110001: dec_d = 4'hC;
      7'b1000010: dec_d = 4'hD;
      7'b0110000: dec_d = 4'hE;
      7'b0111000: dec_d = 4'hF;
      default:    legal_d = 1'b0;
    endcase
  end

  always_comb begin
    same_d    = (seg7 == cand_q);
    // Fires exactly once per stable run: scnt saturates at the maximum afterwards.
    accept_d  = same_d && (scnt_q == SCNT_PRE);
    inc_d     = digit_q + 4'd1;   // 4-bit arithmetic gives the F->0 / 0->F wrap
    dec1_d    = digit_q - 4'd1;
    is_up_d   = (dec_d == inc_d);
    is_down_d = (dec_d == dec1_d);
    count_d   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      cand_q    <= NO_PATTERN;
      scnt_q    <= 8'd0;
      held_q    <= NO_PATTERN;
      digit_q   <= 4'h0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      jump_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      jump_q    <= 1'b0;

      // Stability filter: restart on any change, otherwise count up to the max.
      if (!same_d) begin
        cand_q <= seg7;
        scnt_q <= 8'd1;
      end else if (scnt_q != SCNT_MAX) begin
        scnt_q <= scnt_q + 8'd1;
      end

      if (accept_d) begin
        if (!legal_d) begin
          // Forget the held glyph so the next legal one always reports valid.
          illegal_q <= 1'b1;
          held_q    <= NO_PATTERN;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              state_q <= ST_TRACK;
              digit_q <= dec_d;
              held_q  <= seg7;
              valid_q <= 1'b1;
              count_q <= count_d;
            end
            ST_TRACK: begin
              // Same glyph as the one held: a glitch returned, nothing new.
              if (seg7 != held_q) begin
                digit_q <= dec_d;
                held_q  <= seg7;
                valid_q <= 1'b1;
                up_q    <= is_up_d;
                down_q  <= is_down_d;
                // Same digit after an illegal gap reports valid with no direction.
                jump_q  <= !is_up_d && !is_down_d && (dec_d != digit_q);
                count_q <= count_d;
              end
            end
            default: state_q <= ST_EMPTY;
          endcase
        end
      end
    end
  end

  assign digit        = digit_q;
  assign valid        = valid_q;
  assign illegal      = illegal_q;
  assign dir_up       = up_q;
  assign dir_down     = down_q;
  assign jump         = jump_q;
  assign accept_count = count_q;

endmodule
